// File: rtl/registro_pkg.sv
// registro_pkg: mode encoding shared by the universal register and its bench.
`default_nettype none

package registro_pkg;
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_SHR  = 2'b11;
endpackage

`default_nettype wire

// File: rtl/ffd_celda.sv
// ffd_celda: one-bit D flip-flop with async active-low reset, sync clear/set and enable.
`default_nettype none

module ffd_celda #(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic set,
   input  logic enable,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q <= RESET_BIT;
      else if (clear)
         q <= 1'b0;
      else if (set)
         q <= 1'b1;
      else if (enable)
         q <= d;
   end

endmodule

`default_nettype wire

// File: rtl/registro_universal.sv
// registro_universal: WIDTH-bit universal register (hold/load/shift up/shift down).
// Define ROTATE_EN to let rot select wrap-around fill on shifts.
`default_nettype none

module registro_universal
   import registro_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             set,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             rot,
   input  logic             sin_lsb,
   input  logic             sin_msb,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn,
   output logic             sout_msb,
   output logic             sout_lsb
);

   logic fill_lsb;
   logic fill_msb;

`ifdef ROTATE_EN
   assign fill_lsb = rot ? Q[WIDTH-1] : sin_lsb;
   assign fill_msb = rot ? Q[0]       : sin_msb;
`else
   logic unused_rot;
   assign unused_rot = rot;
   assign fill_lsb   = sin_lsb;
   assign fill_msb   = sin_msb;
`endif

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         logic from_below;
         logic from_above;
         logic next_d;

         // Edge bits take the fill value instead of a non-existent neighbour.
         if (i == 0) begin : g_lsb
            assign from_below = fill_lsb;
         end else begin : g_lsb_n
            assign from_below = Q[i-1];
         end

         if (i == WIDTH-1) begin : g_msb
            assign from_above = fill_msb;
         end else begin : g_msb_n
            assign from_above = Q[i+1];
         end

         always_comb begin
            next_d = Q[i];
            case (mode)
               MODE_LOAD: next_d = D[i];
               MODE_SHL:  next_d = from_below;
               MODE_SHR:  next_d = from_above;
               default:   next_d = Q[i];
            endcase
         end

         ffd_celda #(
            .RESET_BIT (RESET_VAL[i])
         ) u_celda (
            .clk    (clk),
            .reset  (reset),
            .clear  (clear),
            .set    (set),
            .enable (enable),
            .d      (next_d),
            .q      (Q[i])
         );
      end
   endgenerate

   assign Qn       = ~Q;
   assign sout_msb = Q[WIDTH-1];
   assign sout_lsb = Q[0];

endmodule

`default_nettype wire

// File: tb/tb_registro_universal.sv
// tb_registro_universal: directed self-checking bench for registro_universal (WIDTH=8).
`default_nettype none

module tb_registro_universal;
   import registro_pkg::*;

   logic       clk = 1'b0;
   logic       reset, clear, set, enable, rot, sin_lsb, sin_msb;
   logic [1:0] mode;
   logic [7:0] D;
   logic [7:0] Q, Qn;
   logic       sout_msb, sout_lsb;

   int checks = 0;
   int errors = 0;

   registro_universal #(
      .WIDTH     (8),
      .RESET_VAL (8'h00)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .set      (set),
      .enable   (enable),
      .mode     (mode),
      .rot      (rot),
      .sin_lsb  (sin_lsb),
      .sin_msb  (sin_msb),
      .D        (D),
      .Q        (Q),
      .Qn       (Qn),
      .sout_msb (sout_msb),
      .sout_lsb (sout_lsb)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] v);
      clear = 0; set = 0; enable = 1; mode = MODE_LOAD; D = v;
      tick();
   endtask

   logic [7:0] serial_bits;
   logic [7:0] exp_rot_shl, exp_rot_shr;

   initial begin
`ifdef ROTATE_EN
      exp_rot_shl = 8'h03;
      exp_rot_shr = 8'hC0;
`else
      exp_rot_shl = 8'h02;
      exp_rot_shr = 8'h40;
`endif
      reset = 0; clear = 0; set = 0; enable = 0; mode = MODE_HOLD;
      rot = 0; sin_lsb = 0; sin_msb = 0; D = 8'h00;
      #3;
      chk("reset_q", Q, 8'h00);
      chk("reset_qn", Qn, 8'hFF);
      chk("reset_souts", {6'b0, sout_msb, sout_lsb}, 8'h00);

      @(negedge clk);
      reset = 1;
      load(8'hA5);
      chk("load_a5", Q, 8'hA5);
      chk("load_a5_qn", Qn, 8'h5A);

      // Asynchronous reset pulse between edges
      reset = 0;
      #2;
      chk("async_reset_q", Q, 8'h00);
      chk("async_reset_qn", Qn, 8'hFF);
      reset = 1;
      load(8'h3C);
      chk("first_edge_after_reset", Q, 8'h3C);

      clear = 1; set = 1; enable = 1; mode = MODE_LOAD; D = 8'hAA;
      tick();
      chk("clear_beats_set", Q, 8'h00);
      clear = 0; set = 1; enable = 0;
      tick();
      chk("set_ignores_enable", Q, 8'hFF);

      load(8'h5A);
      chk("load_5a", Q, 8'h5A);
      enable = 0; D = 8'h00; mode = MODE_LOAD;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("enable_low_hold", Q, 8'h5A);
      end

      load(8'h81);
      mode = MODE_SHL; rot = 0; sin_lsb = 1;
      tick();
      chk("shl_sin1", Q, 8'h03);
      chk("shl_sout_msb", {7'b0, sout_msb}, 8'h00);
      chk("shl_sout_lsb", {7'b0, sout_lsb}, 8'h01);

      load(8'h81);
      mode = MODE_SHL; rot = 1; sin_lsb = 0;
      tick();
      chk("shl_rot", Q, exp_rot_shl);

      load(8'h81);
      mode = MODE_SHR; rot = 1; sin_msb = 0;
      tick();
      chk("shr_rot", Q, exp_rot_shr);

      load(8'h81);
      mode = MODE_SHR; rot = 0; sin_msb = 1;
      tick();
      chk("shr_sin1", Q, 8'hC0);

      // Serial-in toward LSB with a stall in the middle; first bit lands in Q[0]
      load(8'hFF);
      serial_bits = 8'b0100_1101;
      mode = MODE_SHR; rot = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            enable = 0; sin_msb = 0;
            tick();
         end
         enable = 1;
         sin_msb = serial_bits[k];
         tick();
      end
      chk("serial_in_4d", Q, 8'h4D);

      enable = 1; mode = MODE_HOLD;
      tick();
      chk("mode_hold", Q, 8'h4D);

      mode = MODE_SHL; sin_lsb = 1;
      tick();
      chk("shl_from_4d", Q, 8'h9B);
      reset = 0;
      #1;
      chk("reset_mid_shift", Q, 8'h00);
      tick();
      chk("reset_held", Q, 8'h00);
      reset = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/registro_universal.md
# registro_universal

Parametrised universal register: WIDTH D-type flip-flops sharing one clock, with asynchronous reset, synchronous clear/set, a clock enable, and four operating modes (hold, parallel load, shift toward MSB, shift toward LSB). It supersedes the single-bit FFD wherever the datapath needs multi-bit storage or serial/parallel conversion. Each slice is an FFD-equivalent cell, and Qn is kept as a complementary output.

## Interface
- WIDTH, 8, register width in bits; legal range ≥1.
- RESET_VAL, {WIDTH{1'b0}}, value loaded by reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- clear  in  1  synchronous clear to all zeros; ignores enable.
- set  in  1  synchronous set to all ones; ignores enable.
- enable  in  1  gates the mode operation; 0 = hold.
- mode  in  2  00 hold, 01 parallel load, 10 shift toward MSB, 11 shift toward LSB.
- rot  in  1  rotate select for shift modes; active only with ROTATE_EN.
- sin_lsb  in  1  serial input written into bit 0 on a shift toward MSB.
- sin_msb  in  1  serial input written into bit WIDTH-1 on a shift toward LSB.
- D  in  WIDTH  parallel load data.
- Q  out  WIDTH  register contents.
- Qn  out  WIDTH  ~Q, always.
- sout_msb  out  1  Q[WIDTH-1].
- sout_lsb  out  1  Q[0].

## Operation
Priority, highest first: reset, clear, set, enable, mode.
- reset=0: Q = RESET_VAL immediately, with no clock required. Held while reset=0.
- clear=1: Q ← 0 on the edge. If set=1 at the same time, clear wins.
- set=1 (clear=0): Q ← all ones.
- enable=0: Q holds, regardless of mode.
- enable=1, mode 00: hold.
- enable=1, mode 01: Q ← D.
- enable=1, mode 10: Q ← {Q[WIDTH-2:0], sin_lsb}. With rot=1 and ROTATE_EN defined, the fill bit is Q[WIDTH-1].
- enable=1, mode 11: Q ← {sin_msb, Q[WIDTH-1:1]}. With rot=1 and ROTATE_EN defined, the fill bit is Q[0].
- WIDTH=1: shift toward MSB loads sin_lsb; shift toward LSB loads sin_msb; rotate holds.
- Qn, sout_msb and sout_lsb are purely combinational from Q. There is no other state.
- Reset values: Q=RESET_VAL, Qn=~RESET_VAL, sout_msb=RESET_VAL[WIDTH-1], sout_lsb=RESET_VAL[0].

## Timing
- All synchronous updates occur on the rising clk edge, with one-cycle latency from input to Q.
- Qn and the serial outputs follow Q in the same delta/cycle; they are never registered separately.
- Reset assertion takes effect asynchronously, including mid-shift sequences.
- Reset deassertion must meet recovery timing. The first rising edge with reset=1 performs the normal operation selected at that edge.
- Inputs must be stable around each rising edge. No handshake exists; the register accepts every enabled edge.
- A serial shift of N bits takes N enabled edges. An enable=0 edge inserts a stall without loss of data.

## Configuration
- ROTATE_EN defined: the rot port selects rotate (wrap-around fill) in modes 10/11.
- ROTATE_EN undefined: the rot port is still present but ignored. Shifts always use sin_lsb/sin_msb. No rotate logic is synthesised.

## Structure
- Shared package registro_pkg holds the mode encoding constants: MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_SHL=2'b10, MODE_SHR=2'b11.
- Natural sub-module ffd_celda: a one-bit flip-flop with async active-low reset, reset value, sync clear/set, enable, and D. It is instantiated WIDTH times via generate.
- Per-bit next-D selection (mux of D, neighbour bits, serial inputs) lives in the top module.

## Test plan
Default configuration: WIDTH=8, RESET_VAL=0, ROTATE_EN defined unless noted.
- reset=0 pulse mid-cycle while Q=8'hA5 -> Q=8'h00 and Qn=8'hFF before the next edge; the first edge after release with mode 01, D=8'h3C -> Q=8'h3C.
- clear=1 and set=1 on the same edge with Q=8'h3C -> Q=8'h00. The next edge with set=1 only -> Q=8'hFF, regardless of enable=0.
- mode 01, D=8'h5A, enable=1 -> Q=8'h5A. Then enable=0, D=8'h00, mode 01 for 3 edges -> Q stays 8'h5A.
- Q=8'h81, mode 10, rot=0, sin_lsb=1 -> Q=8'h03 and sout_msb=0. With rot=1 from Q=8'h81 -> Q=8'h03. Mode 11, rot=1 from Q=8'h81 -> Q=8'hC0.
- Serial-in sequence 1,0,1,1,0,0,1,0 into sin_msb over 8 edges in mode 11 -> Q=8'h4D (first bit ends at Q[0]).
- ROTATE_EN undefined, Q=8'h81, mode 10, rot=1, sin_lsb=0 -> Q=8'h02 (rot ignored).
